// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the ID/EX stage and the iterative RV32M/RV64M muldiv unit.
// Operands and rd are presented with start; the hazard unit consumes stall_req, and EX/MEM consumes valid/result/rd_out.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            stall_req;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, stall_req, valid, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, stall_req, valid, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Latency: XLEN+1 cycles from accepted start to the valid strobe; 1 cycle for zero/div-by-zero/overflow fast paths.
// Backpressure: none accepted; the unit stalls the pipeline itself via stall_req while it iterates.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   b_mag_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic              busy_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              is_div;
    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic              fast;
    logic              can_accept;
    logic              accept;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   fast_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rem_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   fin_res;

    // Operand decode for the request currently on the bus.
    always_comb begin
        is_div     = bus.funct3[2];
        a_sgn      = is_div ? ~bus.funct3[0] : (bus.funct3[1] ^ bus.funct3[0]);
        b_sgn      = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
        a_neg      = a_sgn & bus.op_a[XLEN-1];
        b_neg      = b_sgn & bus.op_b[XLEN-1];
        a_mag      = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
        b_mag      = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
        fast       = 1'b0;
        fast_val   = '0;
        if (is_div) begin
            if (bus.op_b == '0) begin
                fast     = 1'b1;
                fast_val = bus.funct3[1] ? bus.op_a : {XLEN{1'b1}};
            end else if (!bus.funct3[0] && bus.op_a == MIN_NEG && bus.op_b == {XLEN{1'b1}}) begin
                fast     = 1'b1;
                fast_val = bus.funct3[1] ? {XLEN{1'b0}} : bus.op_a;
            end
        end else if (bus.op_a == '0 || bus.op_b == '0) begin
            fast     = 1'b1;
            fast_val = '0;
        end
        can_accept = (state == IDLE) || (state == DONE);
        accept     = bus.start & ~bus.flush & can_accept;
    end

    // One iteration step; acc holds {hi,lo} of the product, or {remainder,dividend/quotient}.
    always_comb begin
        mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
        div_rem_sh = acc[2*XLEN-1:XLEN-1];
        div_diff   = div_rem_sh - {1'b0, b_mag_q};
        if (f3_q[2]) begin
            if (!div_diff[XLEN]) begin
                acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the value produced by the final step.
    always_comb begin
        prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        div_raw  = f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (f3_q[2]) begin
            fin_res = neg_q ? (~div_raw + 1'b1) : div_raw;
        end else if (f3_q[1:0] == 2'b00) begin
            fin_res = prod_fix[XLEN-1:0];
        end else begin
            fin_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            acc      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (accept) begin
                            f3_q    <= bus.funct3;
                            rd_q    <= bus.rd_in;
                            b_mag_q <= b_mag;
                            // Remainder follows the dividend; everything else follows the sign product.
                            neg_q   <= (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
                            if (fast) begin
                                state    <= DONE;
                                cnt      <= '0;
                                valid_q  <= 1'b1;
                                result_q <= fast_val;
                                rd_out_q <= bus.rd_in;
                            end else begin
                                state  <= CALC;
                                cnt    <= CNT_W'(XLEN);
                                busy_q <= 1'b1;
                                acc    <= {{XLEN{1'b0}}, a_mag};
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        acc <= acc_nxt;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= fin_res;
                            rd_out_q <= rd_q;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
    assign bus.stall_req = (bus.start & can_accept & ~bus.flush & ~fast) | busy_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit (XLEN=32 and XLEN=64) against a scoreboard of expected results.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) b32 ();
    muldiv_unit_if #(.XLEN(64)) b64 ();

    muldiv_unit #(.XLEN(32)) dut   (.clk(clk), .rst(rst), .bus(b32.slave));
    muldiv_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t sb64[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output int lat);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [63:0] sa64;
        logic signed [63:0] sb64v;
        logic [63:0]        p;
        logic               ovf;
        sa    = $signed(a);
        sbv   = $signed(b);
        sa64  = 64'(sa);
        sb64v = 64'(sbv);
        ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        lat   = 33;
        r     = '0;
        case (f)
            F_MUL:    begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            F_MULH:   begin p = sa64 * sb64v; r = p[63:32]; end
            F_MULHSU: begin p = sa64 * $signed({32'h0, b}); r = p[63:32]; end
            F_MULHU:  begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            F_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
            F_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM:    r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
            default:  r = (b == 0) ? a : a % b;
        endcase
        if (!f[2] && (a == 0 || b == 0)) lat = 1;
        if (f[2] && b == 0) lat = 1;
        if (f[2] && !f[0] && ovf) lat = 1;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] res, input int lat, input string tag);
        b32.funct3 = f;
        b32.op_a   = a;
        b32.op_b   = b;
        b32.rd_in  = rd;
        b32.start  = 1'b1;
        sb.push_back('{{32'h0, res}, rd, lat});
        #1;
        check({tag, "_stall_at_start"}, {63'h0, b32.stall_req}, {63'h0, (lat > 1)});
        @(negedge clk);
        b32.start  = 1'b0;
        b32.op_a   = $urandom();
        b32.op_b   = $urandom();
        b32.funct3 = 3'($urandom());
        b32.rd_in  = 5'($urandom());
    endtask

    task automatic wait_result(input string tag);
        int   n;
        int   st;
        exp_t e;
        n  = 1;
        st = 0;
        while (b32.valid !== 1'b1 && n < 200) begin
            if (b32.stall_req === 1'b1) st++;
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {63'h0, b32.valid}, 64'h1);
        check({tag, "_sb_nonempty"}, {63'h0, (sb.size() > 0)}, 64'h1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, {32'h0, b32.result}, e.res);
            check({tag, "_rd"}, {59'h0, b32.rd_out}, {59'h0, e.rd});
            check({tag, "_latency"}, 64'(n), 64'(e.lat));
            check({tag, "_stall_cycles"}, 64'(st), 64'(e.lat - 1));
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] res, input int lat, input string tag);
        issue(f, a, b, rd, res, lat, tag);
        wait_result(tag);
        @(negedge clk);
    endtask

    task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input string tag);
        int   n;
        exp_t e;
        b64.funct3 = f;
        b64.op_a   = a;
        b64.op_b   = b;
        b64.rd_in  = 5'd3;
        b64.start  = 1'b1;
        sb64.push_back('{res, 5'd3, 65});
        @(negedge clk);
        b64.start = 1'b0;
        b64.op_a  = '0;
        b64.op_b  = '0;
        n = 1;
        while (b64.valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {63'h0, b64.valid}, 64'h1);
        e = sb64.pop_front();
        check({tag, "_result"}, b64.result, e.res);
        check({tag, "_latency"}, 64'(n), 64'(e.lat));
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rr;
        int          rl;
        int          vcount;

        rst        = 1'b0;
        b32.start  = 1'b0;
        b32.flush  = 1'b0;
        b32.funct3 = '0;
        b32.op_a   = '0;
        b32.op_b   = '0;
        b32.rd_in  = '0;
        b64.start  = 1'b0;
        b64.flush  = 1'b0;
        b64.funct3 = '0;
        b64.op_a   = '0;
        b64.op_b   = '0;
        b64.rd_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'h0, b32.busy}, 64'h0);
        check("rst_valid", {63'h0, b32.valid}, 64'h0);
        check("rst_result", {32'h0, b32.result}, 64'h0);
        check("rst_rd_out", {59'h0, b32.rd_out}, 64'h0);
        check("rst_stall", {63'h0, b32.stall_req}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, "mul");
        wait_result("mul");
        @(negedge clk);
        check("mul_valid_one_cycle", {63'h0, b32.valid}, 64'h0);
        run(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33, "mulhu");
        run(F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33, "mulh");
        run(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, "mulhsu");
        run(F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33, "div");
        run(F_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33, "rem");
        run(F_REMU,   32'd100,       32'd7,         5'd11, 32'd2,         33, "remu");
        run(F_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        33, "divu");

        // Flush in the 10th CALC cycle: no valid, previous result (14) retained.
        b32.funct3 = F_DIVU;
        b32.op_a   = 32'd200;
        b32.op_b   = 32'd7;
        b32.rd_in  = 5'd13;
        b32.start  = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        repeat (9) @(negedge clk);
        b32.flush = 1'b1;
        @(negedge clk);
        b32.flush = 1'b0;
        check("flush_busy", {63'h0, b32.busy}, 64'h0);
        check("flush_stall", {63'h0, b32.stall_req}, 64'h0);
        check("flush_valid", {63'h0, b32.valid}, 64'h0);
        check("flush_result_kept", {32'h0, b32.result}, 64'd14);
        vcount = 0;
        repeat (40) begin
            if (b32.valid === 1'b1) vcount++;
            @(negedge clk);
        end
        check("flush_no_valid", 64'(vcount), 64'h0);
        run(F_DIVU, 32'd200, 32'd7, 5'd14, 32'd28, 33, "after_flush");

        run(F_DIVU, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1, "divu_by0");
        run(F_REM,  32'd5,         32'd0,         5'd16, 32'd5,         1, "rem_by0");
        run(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1, "div_ovf");
        run(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0,         1, "rem_ovf");
        run(F_MUL,  32'h0,         32'h1234_5678, 5'd19, 32'h0,         1, "mul_zero");

        // Back-to-back: start held high through CALC is ignored, then accepted again in DONE.
        b32.funct3 = F_DIVU;
        b32.op_a   = 32'd9;
        b32.op_b   = 32'd3;
        b32.rd_in  = 5'd20;
        b32.start  = 1'b1;
        sb.push_back('{64'd3, 5'd20, 33});
        sb.push_back('{64'd3, 5'd20, 33});
        @(negedge clk);
        wait_result("b2b_first");
        @(negedge clk);
        b32.start = 1'b0;
        check("b2b_busy", {63'h0, b32.busy}, 64'h1);
        wait_result("b2b_second");
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom());
            ra = $urandom();
            rb = $urandom();
            if (i % 5 == 0) rb = 32'($urandom_range(0, 2));
            if (i % 7 == 3) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            ref_model(rf, ra, rb, rr, rl);
            run(rf, ra, rb, 5'(i), rr, rl, "rnd");
        end

        run64(F_MUL,   64'h1_0000_0000, 64'h1_0000_0000, 64'h0, "x64_mul");
        run64(F_MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, "x64_mulhu");

        // Asynchronous reset in the middle of CALC.
        b32.funct3 = F_MULHU;
        b32.op_a   = 32'd3;
        b32.op_b   = 32'd5;
        b32.rd_in  = 5'd21;
        b32.start  = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_busy", {63'h0, b32.busy}, 64'h0);
        check("arst_valid", {63'h0, b32.valid}, 64'h0);
        check("arst_stall", {63'h0, b32.stall_req}, 64'h0);
        check("arst_result", {32'h0, b32.result}, 64'h0);
        check("arst_rd_out", {59'h0, b32.rd_out}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        repeat (40) begin
            if (b32.valid === 1'b1) vcount++;
            @(negedge clk);
        end
        check("arst_no_valid", 64'(vcount), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the EX stage of the next-generation pipeline core.
- Accepts one M-extension operation from ID/EX and holds the pipeline via stall_req while it iterates.
- Returns the result and destination register one cycle before the EX/MEM latch.
- Operand width is parametrised so the same block serves RV32 and RV64 builds.

Parameters:
XLEN, 32, operand/result width in bits; must be a power of two, at least 8
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
flush  input  1  branch-taken kill; aborts any operation in progress
funct3  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value after forwarding
op_b  input  XLEN  rs2 value after forwarding
rd_in  input  5  destination register
busy  output  1  high in CALC
stall_req  output  1  (start & state in {IDLE,DONE} & ~flush & ~fast-path) | busy; to the hazard unit, freezes PC/IFID/IDEX
valid  output  1  one-cycle result strobe
result  output  XLEN  result; held until the next accepted start
rd_out  output  5  rd of the completed operation

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, valid=0, result=0, rd_out=0, counter=0. All internal accumulators are cleared.
- States are IDLE, CALC and DONE:
  - IDLE: start & ~flush latches funct3, rd_in and operand magnitudes. The next state is CALC with counter=XLEN, or DONE for a fast-path case.
  - CALC: one radix-2 step per cycle; counter decrements. When counter reaches 1, the final step is taken and the next state is DONE.
  - DONE: valid=1 for exactly this cycle and result is registered. start & ~flush here is accepted exactly as in IDLE (back-to-back). Otherwise the next state is IDLE.
- Latency:
  - Normal ops: start at edge N gives valid high during cycle N+XLEN+1. That is XLEN+1 cycles; 33 for XLEN=32.
  - Fast path: valid in cycle N+1.
- Multiply:
  - Shift-add on unsigned magnitudes with a 2*XLEN product register.
  - Sign fix-up in DONE (two's-complement negate of the 2*XLEN product) when the operand signs differ:
    - MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU: neither signed.
  - MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Fast path (no CALC, valid next cycle):
  - op_b==0: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow, op_a=2^(XLEN-1) and op_b=all ones: DIV gives op_a; REM gives 0.
  - MUL family with op_a==0 or op_b==0 gives 0.
- flush:
  - In any state, flush forces the next state to IDLE with valid=0, and result/rd_out are not updated.
  - start is ignored in a cycle where flush=1.
- start while busy is ignored; the pipeline is already stalled.
- Operands are latched at acceptance; later changes on op_a/op_b/funct3/rd_in have no effect.
- Reset asserted mid-CALC: immediate return to IDLE; no valid afterwards.

Test Plan:
- MUL 7 * -3 (op_a=7, op_b=0xFFFFFFFD), XLEN=32 -> stall_req high 33 cycles; valid in cycle N+33; result=0xFFFFFFEB; rd_out=rd_in.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> result=0x00000000. MULHSU 0xFFFFFFFF * 2 -> result=0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> valid next cycle, result=0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, fast path.
- flush asserted at CALC cycle 10 -> IDLE next cycle; no valid pulse; result keeps its previous value. A new start accepted afterwards completes normally.
- Back-to-back: start held high in DONE with DIVU 9/3 -> first valid, then second valid 33 cycles later with result=3. Separately, rst=0 mid-CALC -> busy=0, valid=0 immediately; XLEN=64 instance MUL 2^32 * 2^32 -> result=0, MULHU -> 1.
